bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential shift-and-add-3 (double-dabble) converter from unsigned binary to packed BCD digits.
Sits directly upstream of the per-digit 4-bit `bcd` decode stage; each output nibble feeds one decoder instance.
Uses a start/busy/done handshake and one iteration per clock, so area stays small for wide inputs.

Parameters:
BIN_W, 8, width of the binary input in bits (min 1)
DIGITS, 3, number of BCD output digits (nibbles)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request conversion of bin; honoured only when busy=0
bin  input  BIN_W  unsigned binary operand, sampled on the accepting edge only
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse: bcd and ovf valid and freshly updated
bcd  output  4*DIGITS  packed result; digit 0 (units) at [3:0], digit k at [4k+3:4k]
ovf  output  1  result exceeded 10^DIGITS-1; bcd holds the value modulo 10^DIGITS

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, bcd=0, ovf=0, bit counter=0, scratch registers=0.
- FSM states: IDLE, SHIFT.
- IDLE, start=1 on an edge:
  - bin is loaded into the binary shift register.
  - BCD scratch is cleared, counter is cleared, ovf scratch is cleared.
  - state goes to SHIFT; busy=1 from the next cycle.
- IDLE, start=0: no change; bcd and ovf hold their last values.
- SHIFT, each edge:
  - every scratch digit >=5 gets +3 (per-digit, combinational, evaluated before the shift);
  - then {scratch, binreg} shifts left 1;
  - the bit shifted out of the top digit is ORed into the ovf scratch;
  - the counter increments.
- Final SHIFT edge (counter==BIN_W-1):
  - the shifted scratch is written to bcd and the ovf scratch (including this edge's carry) to ovf;
  - done=1 for exactly the next cycle;
  - busy=0 in that same cycle; state returns to IDLE.
- Latency: start edge to done-high cycle = BIN_W+1 edges; throughput is one conversion per BIN_W+1 cycles.
- start while busy=1 is ignored (no queueing); bin changes while busy have no effect.
- start high during the done cycle is accepted (state is IDLE), so back-to-back conversions need no idle gap.
- Digits are never outside 0-9 on bcd, and the add-3 adjustment never produces a nibble above 12.
- Counter width is $clog2(BIN_W+1).
- Reset asserted mid-conversion: abort immediately to reset values; no done pulse.
- ovf is only meaningful when DIGITS*3.33 < BIN_W; with the defaults, ovf is always 0.

Decomposition:
- Package bcd_pkg:
  - typedef logic [3:0] bcd_digit_t;
  - constants BCD_ADJ_THRESH=5 and BCD_ADJ_ADD=3;
  - enum state_t {IDLE, SHIFT}.
- Sub-module bcd_digit_adj: combinational, in bcd_digit_t -> out bcd_digit_t, applying the add-3 rule. Instantiated DIGITS times by generate.

Test Plan:
- Reset, then start with bin=0 -> done after 9 edges; bcd=12'h000, ovf=0; busy high for exactly 8 cycles.
- bin=255 -> bcd=12'h255; bin=99 -> 12'h099; bin=100 -> 12'h100. For each: done pulse width 1, result stable until the next done.
- start held high continuously with bins 37 then 200:
  - two conversions back-to-back, done at edges 9 and 18;
  - bcd=12'h037 then 12'h200.
- start pulsed at cycle 3 of an active conversion (bin=5, then bin=9) -> ignored; result bcd=12'h005, with a single done only.
- rst_n low at cycle 4 of bin=123 -> busy=0, bcd=0, no done; then bin=123 converts to 12'h123.
- Overflow check with BIN_W=8, DIGITS=2: bin=100 -> bcd=8'h00, ovf=1; bin=99 -> bcd=8'h99, ovf=0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
   localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the next shift.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  bcd_digit_t din,
   output bcd_digit_t dout
);

   assign dout = (din >= BCD_ADJ_THRESH) ? bcd_digit_t'(din + BCD_ADJ_ADD) : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 converter, one binary bit per clock, start/busy/done handshake.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = 4 * DIGITS;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

   state_t              state_q, state_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic [BCD_W-1:0]    scr_q, scr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                ovf_scr_q, ovf_scr_d;
   logic [BCD_W-1:0]    bcd_q, bcd_d;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;
   logic [BCD_W-1:0]    adj;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         bcd_digit_adj u_adj (
            .din  (scr_q[4*gi +: 4]),
            .dout (adj[4*gi +: 4])
         );
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      scr_d     = scr_q;
      cnt_d     = cnt_q;
      ovf_scr_d = ovf_scr_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_d     = bin;
               scr_d     = '0;
               cnt_d     = '0;
               ovf_scr_d = 1'b0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            // The bit leaving the top digit is a carry into 10^DIGITS, i.e. overflow.
            scr_d     = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
            bin_d     = bin_q << 1;
            ovf_scr_d = ovf_scr_q | adj[BCD_W-1];
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               bcd_d   = scr_d;
               ovf_d   = ovf_scr_d;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bin_q     <= '0;
         scr_q     <= '0;
         cnt_q     <= '0;
         ovf_scr_q <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         scr_q     <= scr_d;
         cnt_q     <= cnt_d;
         ovf_scr_q <= ovf_scr_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = done_q;
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench: a 3-digit and a 2-digit converter share stimulus, checked against an arithmetic model.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  bin = 8'd0;
   logic        busy, done, ovf;
   logic [11:0] bcd;
   logic        busy2, done2, ovf2;
   logic [7:0]  bcd2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
   );

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
   );

   function automatic logic [31:0] ref_bcd(input int v, input int d);
      logic [31:0] r;
      int p;
      r = '0;
      p = 1;
      for (int k = 0; k < d; k++) begin
         r |= 32'((v / p) % 10) << (4 * k);
         p *= 10;
      end
      return r;
   endfunction

   function automatic logic ref_ovf(input int v, input int d);
      return v >= (d == 2 ? 100 : 1000);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full conversion: start pulse, bounded wait for done, then result and pulse-width checks.
   task automatic run_conv(input int v);
      int n, busy_cnt;
      start = 1'b1;
      bin   = 8'(v);
      tick();
      start = 1'b0;
      bin   = ~bin;
      n = 1;
      busy_cnt = 0;
      while (!done && n < 40) begin
         if (busy) busy_cnt++;
         tick();
         n++;
      end
      check("latency", 32'(n), 32'd9);
      check("busy_len", 32'(busy_cnt), 32'd8);
      check("busy_at_done", 32'(busy), 32'd0);
      check("bcd3", 32'(bcd), ref_bcd(v, 3));
      check("ovf3", 32'(ovf), 32'(ref_ovf(v, 3)));
      check("done2_align", 32'(done2), 32'd1);
      check("bcd2", 32'(bcd2), ref_bcd(v, 2));
      check("ovf2", 32'(ovf2), 32'(ref_ovf(v, 2)));
      $display("conv bin=%0d bcd=%03h ovf=%0b bcd2=%02h ovf2=%0b latency=%0d", v, bcd, ovf, bcd2, ovf2, n);
      tick();
      check("done_width", 32'(done), 32'd0);
      check("bcd_hold", 32'(bcd), ref_bcd(v, 3));
   endtask

   initial begin
      int dones;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_bcd", 32'(bcd), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Idle with start low: nothing happens.
      tick();
      check("idle_busy", 32'(busy), 32'd0);

      run_conv(0);
      run_conv(255);
      run_conv(99);
      run_conv(100);

      // start held high: two back-to-back conversions, done after edges 9 and 18.
      start = 1'b1;
      bin   = 8'd37;
      for (int e = 1; e <= 18; e++) begin
         tick();
         if (e == 1) bin = 8'd200;
         check($sformatf("b2b_done_e%0d", e), 32'(done), 32'((e == 9) || (e == 18)));
         if (e == 9)  check("b2b_bcd_37", 32'(bcd), 32'h037);
         if (e == 18) check("b2b_bcd_200", 32'(bcd), 32'h200);
      end
      start = 1'b0;
      $display("b2b conv bcd=%03h", bcd);
      tick();

      // start pulsed during an active conversion is ignored.
      start = 1'b1;
      bin   = 8'd5;
      tick();
      start = 1'b0;
      tick();
      tick();
      start = 1'b1;
      bin   = 8'd9;
      tick();
      start = 1'b0;
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         if (done) begin
            dones++;
            check("ign_bcd", 32'(bcd), 32'h005);
         end
         tick();
      end
      check("ign_done_cnt", 32'(dones), 32'd1);
      $display("ignored-start conv bcd=%03h dones=%0d", bcd, dones);

      // Reset mid-conversion aborts with no done pulse.
      start = 1'b1;
      bin   = 8'd123;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_bcd", 32'(bcd), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      tick();
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < 12; c++) begin
         if (done) dones++;
         tick();
      end
      check("abort_no_done", 32'(dones), 32'd0);
      $display("abort bcd=%03h busy=%0b", bcd, busy);
      run_conv(123);

      // Random operands against the arithmetic model.
      for (int r = 0; r < 20; r++) begin
         run_conv(int'($urandom_range(0, 255)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
